// File: rtl/vga_display_ctrl_pkg.sv
// Shared definitions for the VGA display controller.
// Contents:
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - rgb_t (4:4:4 colour) and coord_t (10-bit scan coordinate)
//   - pix_t, one pixel's worth of DAC-side data as it travels the delay line
//   - in_range(), a half-open interval test used by the sync decode
package vga_display_ctrl_pkg;

  localparam int CLK_DIV_DEF    = 4;
  localparam int H_VISIBLE_DEF  = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_VISIBLE_DEF  = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int PIPE_DELAY_DEF = 1;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  typedef logic [11:0] rgb_t;
  typedef logic [9:0]  coord_t;

  typedef struct packed {
    rgb_t rgb;
    logic vis;
    logic hs_n;
    logic vs_n;
  } pix_t;

  // Blank pixel with both syncs inactive (high).
  localparam pix_t PIX_RESET = '{rgb: 12'h000, vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // True when lo <= x < lo+len.
  function automatic logic in_range(input int x, input int lo, input int len);
    return (x >= lo) && (x < lo + len);
  endfunction

endpackage

// File: rtl/vga_display_ctrl_if.sv
// Pixel-scan interface between the display controller and its neighbours.
// master: the display controller (drives scan position, strobes, DAC pins).
// slave : renderers / DAC side (drive colour and drawing flags, read the rest).
//
// Timing contract: there is no valid/ready handshake. h_count/v_count change
// only on a pixel_tick edge; renderers answer combinationally, and
// rgb_HUD/rgb_game are used only when their *_drawing qualifier is high,
// sampled on the clock edge where pixel_tick is high. hsync/vsync/video_on/rgb
// are registered and aligned with each other.
interface vga_display_ctrl_if;
  import vga_display_ctrl_pkg::*;

  coord_t h_count;
  coord_t v_count;
  logic   pixel_tick;
  logic   frame_tick;
  rgb_t   rgb_HUD;
  logic   HUD_drawing;
  rgb_t   rgb_game;
  logic   game_drawing;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  rgb_t   rgb;

  modport master (
    output h_count, v_count, pixel_tick, frame_tick,
    output hsync, vsync, video_on, rgb,
    input  rgb_HUD, HUD_drawing, rgb_game, game_drawing
  );

  modport slave (
    input  h_count, v_count, pixel_tick, frame_tick,
    input  hsync, vsync, video_on, rgb,
    output rgb_HUD, HUD_drawing, rgb_game, game_drawing
  );

endinterface

// File: rtl/vga_display_ctrl_sync_counter.sv
// vga_sync_counter: pixel clock divider, scan position counters and raw
// (undelayed) timing decode.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   h_count_o       current column, 0..H_TOTAL-1 (registered)
//   v_count_o       current line,   0..V_TOTAL-1 (registered)
//   pixel_tick_o    registered strobe, high while divider == CLK_DIV-1
//   frame_tick_o    one-clk pulse after the edge that enters (0, V_VISIBLE)
//   vis_o           raw visible-region flag for the current position
//   hs_n_o, vs_n_o  raw active-low sync levels for the current position
module vga_sync_counter
  import vga_display_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic   clk,
  input  logic   reset,
  output coord_t h_count_o,
  output coord_t v_count_o,
  output logic   pixel_tick_o,
  output logic   frame_tick_o,
  output logic   vis_o,
  output logic   hs_n_o,
  output logic   vs_n_o
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  coord_t           h_q, h_d;
  coord_t           v_q, v_d;
  logic             tick_q, tick_d;
  logic             frame_q, frame_d;

  always_comb begin
    div_d   = (int'(div_q) == CLK_DIV - 1) ? '0 : div_q + 1'b1;
    // Registered strobe: computed from the next divider value so the flop
    // is high exactly while div_q sits at CLK_DIV-1.
    tick_d  = (int'(div_d) == CLK_DIV - 1);
    h_d     = h_q;
    v_d     = v_q;
    frame_d = 1'b0;
    if (tick_q) begin
      if (int'(h_q) == H_TOT - 1) begin
        h_d     = '0;
        v_d     = (int'(v_q) == V_TOT - 1) ? '0 : coord_t'(int'(v_q) + 1);
        // This edge moves the scan to (0, V_VISIBLE): start of vertical blank.
        frame_d = (int'(v_q) == V_VISIBLE - 1);
      end else begin
        h_d = coord_t'(int'(h_q) + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign h_count_o    = h_q;
  assign v_count_o    = v_q;
  assign pixel_tick_o = tick_q;
  assign frame_tick_o = frame_q;

  assign vis_o  = (int'(h_q) < H_VISIBLE) && (int'(v_q) < V_VISIBLE);
  assign hs_n_o = !in_range(int'(h_q), H_VISIBLE + H_FP, H_SYNC);
  assign vs_n_o = !in_range(int'(v_q), V_VISIBLE + V_FP, V_SYNC);

endmodule

// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: VGA scan source and output stage.
// Generates the scan position and strobes, merges HUD and game colours by
// layer priority, and delays colour/sync/visible together by PIPE_DELAY pixel
// ticks so they leave the block aligned.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   bus          vga_display_ctrl_if.master: h_count, v_count, pixel_tick,
//                frame_tick, hsync, vsync, video_on, rgb out;
//                rgb_HUD, HUD_drawing, rgb_game, game_drawing in
module vga_display_ctrl
  import vga_display_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic               clk,
  input  logic               reset,
  vga_display_ctrl_if.master bus
);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   pix_tick;
  logic   frm_tick;
  logic   vis;
  logic   hs_n;
  logic   vs_n;

  vga_sync_counter #(
    .CLK_DIV   (CLK_DIV),
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_sync (
    .clk          (clk),
    .reset        (reset),
    .h_count_o    (h_cnt),
    .v_count_o    (v_cnt),
    .pixel_tick_o (pix_tick),
    .frame_tick_o (frm_tick),
    .vis_o        (vis),
    .hs_n_o       (hs_n),
    .vs_n_o       (vs_n)
  );

  // Layer priority: HUD over game over black; blanking forces black
  // whatever the renderers claim.
  pix_t mux_pix;

  always_comb begin
    mux_pix      = PIX_RESET;
    mux_pix.vis  = vis;
    mux_pix.hs_n = hs_n;
    mux_pix.vs_n = vs_n;
    if (vis) begin
      if (bus.HUD_drawing) begin
        mux_pix.rgb = bus.rgb_HUD;
      end else if (bus.game_drawing) begin
        mux_pix.rgb = bus.rgb_game;
      end
    end
  end

  // Delay line advanced only on pixel_tick, so every stage (and therefore
  // every pin) holds its value between ticks. Reset clears it to blank so no
  // stale colour can be emitted after release.
  pix_t pipe_q [PIPE_DELAY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= PIX_RESET;
      end
    end else if (pix_tick) begin
      pipe_q[0] <= mux_pix;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.h_count    = h_cnt;
  assign bus.v_count    = v_cnt;
  assign bus.pixel_tick = pix_tick;
  assign bus.frame_tick = frm_tick;
  assign bus.rgb        = pipe_q[PIPE_DELAY-1].rgb;
  assign bus.video_on   = pipe_q[PIPE_DELAY-1].vis;
  assign bus.hsync      = pipe_q[PIPE_DELAY-1].hs_n;
  assign bus.vsync      = pipe_q[PIPE_DELAY-1].vs_n;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl.
// Two instances share clk/reset: u_dut uses a shrunken timing so whole frames
// fit in a short run (PIPE_DELAY = 3); u_full uses the default 640x480 timing
// with constant renderer inputs and is checked over its first line.
// Expected values come from a position model: after m_clk clocks since
// release, n = m_clk / CLK_DIV ticks have occurred, the scan sits at
// (n mod H_TOTAL, (n / H_TOTAL) mod V_TOTAL), and pins show the pixel sampled
// PIPE_DELAY ticks earlier (kept in exp_q).
module tb_vga_display_ctrl;

  localparam int CD = 4;
  localparam int HV = 32, HF = 4, HS = 6, HB = 6;
  localparam int VV = 20, VF = 3, VS = 2, VB = 4;
  localparam int PD = 3;
  localparam int HT = HV + HF + HS + HB;   // 48
  localparam int VT = VV + VF + VS + VB;   // 29
  localparam logic [14:0] PIX_RST = 15'h6000;  // {hsync,vsync,video_on,rgb}

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_display_ctrl_if bus ();
  vga_display_ctrl_if fbus ();

  vga_display_ctrl #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(PD)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus));

  vga_display_ctrl u_full (.clk(clk), .reset(reset), .bus(fbus));

  logic [36:0] dut_vec;
  logic [35:0] fvec;
  assign dut_vec = {bus.h_count, bus.v_count, bus.pixel_tick, bus.frame_tick,
                    bus.hsync, bus.vsync, bus.video_on, bus.rgb};
  assign fvec    = {fbus.h_count, fbus.v_count, fbus.pixel_tick,
                    fbus.hsync, fbus.vsync, fbus.video_on, fbus.rgb};

  // model state and scoreboard
  int          m_clk = 0;
  logic [14:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [14:0] ref_pix(input int h, input int v, input int hv, input int hf,
                                          input int hs, input int vv, input int vf, input int vs,
                                          input logic hd, input logic [11:0] rh,
                                          input logic gd, input logic [11:0] rg);
    logic vis, hs_n, vs_n;
    logic [11:0] c;
    vis  = (h < hv) && (v < vv);
    hs_n = !((h >= hv + hf) && (h < hv + hf + hs));
    vs_n = !((v >= vv + vf) && (v < vv + vf + vs));
    c = 12'h000;
    if (vis && hd) c = rh;
    else if (vis && gd) c = rg;
    return {hs_n, vs_n, vis, c};
  endfunction

  function automatic logic [36:0] exp_vec();
    int n, h, v;
    logic pt, ft;
    n  = m_clk / CD;
    h  = n % HT;
    v  = (n / HT) % VT;
    pt = (m_clk % CD == CD - 1);
    ft = (m_clk > 0) && (m_clk % CD == 0) && (h == 0) && (v == VV);
    return {10'(h), 10'(v), pt, ft, exp_q[0]};
  endfunction

  function automatic logic [35:0] exp_full();
    int n, p;
    logic [14:0] pix;
    n   = m_clk / CD;
    pix = PIX_RST;
    if (n >= 1) begin
      p   = n - 1;
      pix = ref_pix(p % 800, (p / 800) % 525, 640, 16, 96, 480, 10, 2,
                    1'b1, 12'hF0F, 1'b1, 12'h0F0);
    end
    return {10'(n % 800), 10'((n / 800) % 525), (m_clk % CD == CD - 1), pix};
  endfunction

  // driver tasks
  task automatic drive_rand();
    bus.HUD_drawing  = 1'($urandom_range(0, 1));
    bus.rgb_HUD      = 12'($urandom);
    bus.game_drawing = 1'($urandom_range(0, 1));
    bus.rgb_game     = 12'($urandom);
  endtask

  // Advance one clock (negedge to negedge), updating the model at the posedge.
  task automatic step_clk();
    int n;
    @(posedge clk);
    if (reset) begin
      m_clk = 0;
      exp_q.delete();
      repeat (PD) exp_q.push_back(PIX_RST);
    end else begin
      if (m_clk % CD == CD - 1) begin
        n = m_clk / CD;
        exp_q.push_back(ref_pix(n % HT, (n / HT) % VT, HV, HF, HS, VV, VF, VS,
                                bus.HUD_drawing, bus.rgb_HUD, bus.game_drawing, bus.rgb_game));
        void'(exp_q.pop_front());
      end
      m_clk++;
    end
    @(negedge clk);
  endtask

  // Run (with random renderer inputs) until the scan has just entered
  // frame position pos = v*HT + h.
  task automatic reach(input int pos);
    for (int i = 0; i < HT * VT * CD + CD; i++) begin
      if (m_clk > 0 && m_clk % CD == 0 && (m_clk / CD) % (HT * VT) == pos) break;
      drive_rand();
      step_clk();
    end
  endtask

  task automatic test_reset();
    int first_pt;
    reset = 1'b1;
    bus.HUD_drawing = 1'b1; bus.rgb_HUD = 12'hFFF;
    bus.game_drawing = 1'b1; bus.rgb_game = 12'h0F0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      total++;
      if (dut_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}) begin
        bad++;
        $display("FAIL reset_state clk=%0d got=%h exp=%h", i, dut_vec,
                 {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
      end
    end
    reset = 1'b0;
    first_pt = -1;
    for (int i = 0; i < 2 * CD; i++) begin
      step_clk();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL post_reset_vec t=%0d got=%h exp=%h", m_clk, dut_vec, exp_vec());
      end
      if (bus.pixel_tick && first_pt < 0) first_pt = m_clk;
    end
    total++;
    if (first_pt !== CD - 1) begin
      bad++;
      $display("FAIL first_pixel_tick got=%0d exp=%0d", first_pt, CD - 1);
    end
  endtask

  task automatic test_line();
    int low_clks, first_low;
    low_clks = 0;
    first_low = -1;
    reach(2 * HT);
    for (int i = 0; i < HT * CD; i++) begin
      drive_rand();
      step_clk();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL line_vec t=%0d got=%h exp=%h", m_clk, dut_vec, exp_vec());
      end
      if (!bus.hsync) begin
        low_clks++;
        if (first_low < 0) first_low = (m_clk / CD) % HT;
      end
    end
    total++;
    if (low_clks !== HS * CD) begin
      bad++;
      $display("FAIL hsync_width got=%0d exp=%0d", low_clks, HS * CD);
    end
    total++;
    if (first_low !== HV + HF + PD) begin
      bad++;
      $display("FAIL hsync_start got=%0d exp=%0d", first_low, HV + HF + PD);
    end
  endtask

  task automatic test_priority();
    logic [11:0] obs [0:PD+1];
    reach(4 * HT + 18);
    bus.HUD_drawing = 1'b1; bus.rgb_HUD = 12'hFFF;
    bus.game_drawing = 1'b1; bus.rgb_game = 12'h00F;
    repeat (CD) step_clk();
    obs[0] = bus.rgb;
    bus.HUD_drawing = 1'b0;
    repeat (CD) step_clk();
    obs[1] = bus.rgb;
    bus.game_drawing = 1'b0;
    repeat (CD) step_clk();
    obs[2] = bus.rgb;
    for (int k = 3; k <= PD + 1; k++) begin
      repeat (CD) step_clk();
      obs[k] = bus.rgb;
    end
    total++;
    if (obs[PD-1] !== 12'hFFF) begin
      bad++;
      $display("FAIL prio_hud got=%h exp=fff", obs[PD-1]);
    end
    total++;
    if (obs[PD] !== 12'h00F) begin
      bad++;
      $display("FAIL prio_game got=%h exp=00f", obs[PD]);
    end
    total++;
    if (obs[PD+1] !== 12'h000) begin
      bad++;
      $display("FAIL prio_none got=%h exp=000", obs[PD+1]);
    end
  endtask

  task automatic test_blanking();
    reach(5 * HT + HV + HF + 2);
    bus.HUD_drawing = 1'b1; bus.rgb_HUD = 12'hF00;
    bus.game_drawing = 1'b1; bus.rgb_game = 12'h0F0;
    repeat (PD * CD) step_clk();
    total++;
    if ({bus.rgb, bus.video_on, bus.hsync} !== {12'h000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL blanking got rgb=%h vid=%b hs=%b exp rgb=000 vid=0 hs=0",
               bus.rgb, bus.video_on, bus.hsync);
    end
  endtask

  task automatic test_frame();
    int fts, vs_clks;
    fts = 0;
    vs_clks = 0;
    reach(0);
    for (int i = 0; i < HT * VT * CD; i++) begin
      drive_rand();
      step_clk();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL frame_vec t=%0d got=%h exp=%h", m_clk, dut_vec, exp_vec());
      end
      if (bus.frame_tick) fts++;
      if (!bus.vsync) vs_clks++;
    end
    total++;
    if (fts !== 1) begin
      bad++;
      $display("FAIL frame_tick_count got=%0d exp=1", fts);
    end
    total++;
    if (vs_clks !== VS * HT * CD) begin
      bad++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_clks, VS * HT * CD);
    end
  endtask

  task automatic test_mid_reset();
    reach(10 * HT + 20);
    drive_rand();
    step_clk();
    step_clk();
    reset = 1'b1;
    step_clk();
    total++;
    if (dut_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", dut_vec,
               {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    end
    total++;
    if ({fbus.h_count, fbus.v_count, fbus.hsync, fbus.vsync, fbus.rgb} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 12'h000}) begin
      bad++;
      $display("FAIL mid_reset_full got h=%0d v=%0d hs=%b vs=%b rgb=%h exp 0 0 1 1 000",
               fbus.h_count, fbus.v_count, fbus.hsync, fbus.vsync, fbus.rgb);
    end
    bus.HUD_drawing = 1'b1; bus.rgb_HUD = 12'hABC;
    bus.game_drawing = 1'b0; bus.rgb_game = 12'h123;
    step_clk();
    reset = 1'b0;
    for (int i = 0; i < (PD + 1) * CD; i++) begin
      step_clk();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL refill_vec t=%0d got=%h exp=%h", m_clk, dut_vec, exp_vec());
      end
      total++;
      if (bus.rgb !== ((m_clk >= PD * CD) ? 12'hABC : 12'h000)) begin
        bad++;
        $display("FAIL refill_rgb t=%0d got=%h exp=%h", m_clk, bus.rgb,
                 (m_clk >= PD * CD) ? 12'hABC : 12'h000);
      end
    end
  endtask

  task automatic test_line_full();
    int low_clks, first_low;
    low_clks = 0;
    first_low = -1;
    while (m_clk < 801 * CD) begin
      step_clk();
      total++;
      if (fvec !== exp_full()) begin
        bad++;
        $display("FAIL full_vec t=%0d got=%h exp=%h", m_clk, fvec, exp_full());
      end
      if (m_clk == 799 * CD) begin
        total++;
        if ({fbus.h_count, fbus.v_count} !== {10'd799, 10'd0}) begin
          bad++;
          $display("FAIL full_pre_wrap got h=%0d v=%0d exp 799 0", fbus.h_count, fbus.v_count);
        end
      end
      if (m_clk == 800 * CD) begin
        total++;
        if ({fbus.h_count, fbus.v_count} !== {10'd0, 10'd1}) begin
          bad++;
          $display("FAIL full_wrap got h=%0d v=%0d exp 0 1", fbus.h_count, fbus.v_count);
        end
      end
      if (!fbus.hsync) begin
        low_clks++;
        if (first_low < 0) first_low = (m_clk / CD) % 800;
      end
    end
    total++;
    if (low_clks !== 96 * CD) begin
      bad++;
      $display("FAIL full_hsync_width got=%0d exp=%0d", low_clks, 96 * CD);
    end
    total++;
    if (first_low !== 657) begin
      bad++;
      $display("FAIL full_hsync_start got=%0d exp=657", first_low);
    end
  endtask

  initial begin
    bus.HUD_drawing = 1'b0; bus.rgb_HUD = 12'h000;
    bus.game_drawing = 1'b0; bus.rgb_game = 12'h000;
    fbus.HUD_drawing = 1'b1; fbus.rgb_HUD = 12'hF0F;
    fbus.game_drawing = 1'b1; fbus.rgb_game = 12'h0F0;
    @(negedge clk);
    test_reset();
    test_line();
    test_priority();
    test_blanking();
    test_frame();
    test_mid_reset();
    test_line_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
